regfile_wb_arbiter: RTL and testbench

- Writer end of the 32x32 register file write port: sole driver of W_reg, W_data and RegWrite.
- Merges two sources of write-backs:
  - the in-order pipeline WB stage, which is fixed-latency, always wins and has no back-pressure;
  - multi-cycle units (load miss, mult/div), which use a valid/ready handshake and are queued in a FIFO.
- Also gives the hazard unit pending-write lookups.

---
 rtl/regfile_pkg.sv | 28 ++
 rtl/regfile_wb_arbiter_if.sv | 53 +++++
 rtl/wb_fifo.sv | 116 +++++++++++
 rtl/regfile_wb_arbiter.sv | 144 ++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared constants and the write-back request record used by
//               the register-file write-back arbiter and its queue.
// Contents    : REG_ADDR_W, DATA_W, NUM_REGS, ZERO_REG, wb_req_t
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 32;

    // Register 0 is hard-wired to zero; writes to it are never performed.
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

    // One pending write-back. 'valid' is cleared when the write must not
    // reach the register file (target is r0, or a newer pipeline write to
    // the same register has superseded it).
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] dst_reg;
        logic [DATA_W-1:0]     data;
    } wb_req_t;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter_if
// Description : Bus bundle of the register-file write-back arbiter.
//   Primary   : p_valid, p_reg, p_data        (pipeline WB stage, no stall)
//   Secondary : s_valid, s_ready, s_reg, s_data (multi-cycle units)
//   Lookup    : q_reg1, q_reg2 -> q_pend1, q_pend2 (hazard unit)
//   Control   : stall_req (ask pipeline to withhold p_valid)
//   RF port   : W_reg, W_data, RegWrite
//   Modports  : master = client side, slave = arbiter side
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_wb_arbiter_if;
    import regfile_pkg::*;

    logic                  p_valid;
    logic [REG_ADDR_W-1:0] p_reg;
    logic [DATA_W-1:0]     p_data;

    logic                  s_valid;
    logic                  s_ready;
    logic [REG_ADDR_W-1:0] s_reg;
    logic [DATA_W-1:0]     s_data;

    logic [REG_ADDR_W-1:0] q_reg1;
    logic [REG_ADDR_W-1:0] q_reg2;
    logic                  q_pend1;
    logic                  q_pend2;

    logic                  stall_req;

    logic [REG_ADDR_W-1:0] W_reg;
    logic [DATA_W-1:0]     W_data;
    logic                  RegWrite;

    modport master (
        output p_valid, p_reg, p_data,
        output s_valid, s_reg, s_data,
        output q_reg1, q_reg2,
        input  s_ready, q_pend1, q_pend2, stall_req,
        input  W_reg, W_data, RegWrite
    );

    modport slave (
        input  p_valid, p_reg, p_data,
        input  s_valid, s_reg, s_data,
        input  q_reg1, q_reg2,
        output s_ready, q_pend1, q_pend2, stall_req,
        output W_reg, W_data, RegWrite
    );

endinterface : regfile_wb_arbiter_if
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_fifo
// Description : DEPTH-entry queue of secondary write-backs. Every entry carries
//               its own valid bit so that it can be squashed in place by a
//               newer write to the same register, and the queue can be
//               searched by register number for the hazard lookups.
// Ports       : clk, rst_n          clock / async active-low reset
//               i_push, i_push_req  enqueue one request (caller ensures !full)
//               i_pop               drop the head (caller ensures !empty)
//               i_inv_en, i_inv_reg clear valid on all entries for a register
//               i_q_reg1, i_q_reg2  lookup registers
//               o_head              head entry
//               o_empty, o_count    occupancy
//               o_match1, o_match2  a valid entry targets i_q_regK
// Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic                  i_push,
    input  wire wb_req_t               i_push_req,
    input  wire logic                  i_pop,
    input  wire logic                  i_inv_en,
    input  wire logic [REG_ADDR_W-1:0] i_inv_reg,
    input  wire logic [REG_ADDR_W-1:0] i_q_reg1,
    input  wire logic [REG_ADDR_W-1:0] i_q_reg2,
    output wb_req_t                    o_head,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_match1,
    output logic                       o_match2
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]      r_rptr;
    logic [PTR_W-1:0]      r_wptr;
    logic [CNT_W-1:0]      r_count;

    logic [DEPTH-1:0]      w_vld;
    logic [REG_ADDR_W-1:0] w_dst  [DEPTH];
    logic [DATA_W-1:0]     w_data [DEPTH];
    logic [DEPTH-1:0]      w_hit1;
    logic [DEPTH-1:0]      w_hit2;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (i_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        logic                  r_vld;
        logic [REG_ADDR_W-1:0] r_dst;
        logic [DATA_W-1:0]     r_data;

        // Valid bit: a slot is only written by a push into a free slot, and
        // is cleared when popped so that free slots never produce a match.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_vld <= 1'b0;
            end else if (i_push && (r_wptr == PTR_W'(i))) begin
                r_vld <= i_push_req.valid;
            end else if (i_pop && (r_rptr == PTR_W'(i))) begin
                r_vld <= 1'b0;
            end else if (i_inv_en && (r_dst == i_inv_reg)) begin
                r_vld <= 1'b0;
            end
        end

        // Payload needs no reset: it is qualified by r_vld everywhere.
        always_ff @(posedge clk) begin
            if (i_push && (r_wptr == PTR_W'(i))) begin
                r_dst  <= i_push_req.dst_reg;
                r_data <= i_push_req.data;
            end
        end

        assign w_vld[i]  = r_vld;
        assign w_dst[i]  = r_dst;
        assign w_data[i] = r_data;
        assign w_hit1[i] = r_vld && (r_dst == i_q_reg1);
        assign w_hit2[i] = r_vld && (r_dst == i_q_reg2);
    end

    assign o_head.valid   = w_vld[r_rptr];
    assign o_head.dst_reg = w_dst[r_rptr];
    assign o_head.data    = w_data[r_rptr];
    assign o_empty        = (r_count == '0);
    assign o_count        = r_count;
    assign o_match1       = |w_hit1;
    assign o_match2       = |w_hit2;

endmodule : wb_fifo
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Sole writer of the 32x32 register file. Merges the in-order
//               pipeline write-back (always wins, no back-pressure) with
//               queued multi-cycle results, keeps write ordering by squashing
//               queued writes superseded by the pipeline, answers hazard
//               lookups and requests a pipeline stall when the queue starves.
// Ports       : clk    clock, rising edge
//               rst_n  asynchronous active-low reset
//               bus    regfile_wb_arbiter_if.slave (primary, secondary,
//                      lookup, stall_req and register-file write port)
// Parameters  : DEPTH        queue entries (power of 2, >= 2)
//               STARVE_LIMIT blocked cycles before stall_req (>= 1)
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    regfile_wb_arbiter_if.slave bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int ST_W  = $clog2(STARVE_LIMIT + 1);

    localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);
    localparam logic [ST_W-1:0]  c_limit = ST_W'(STARVE_LIMIT);

    logic                  w_s_ready;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_empty;
    logic [CNT_W-1:0]      w_count;
    logic                  w_match1;
    logic                  w_match2;
    wb_req_t               w_push_req;
    wb_req_t               w_head;

    logic                  r_regwrite;
    logic [REG_ADDR_W-1:0] r_wreg;
    logic [DATA_W-1:0]     r_wdata;
    logic [ST_W-1:0]       r_starve;
    logic                  r_stall;

    // ------------------------------------------------------------------
    // Secondary intake. Acceptance depends only on the registered count,
    // so a full queue refuses even if it pops in the same cycle.
    // ------------------------------------------------------------------
    assign w_s_ready = rst_n && (w_count < c_depth);
    assign w_push    = bus.s_valid && w_s_ready;

    // A request is enqueued already dead if it targets r0, or if the
    // pipeline writes the same register this cycle (the pipeline value is
    // newer and must not be overwritten later).
    assign w_push_req.valid   = (bus.s_reg != ZERO_REG) &&
                                !(bus.p_valid && (bus.p_reg == bus.s_reg));
    assign w_push_req.dst_reg = bus.s_reg;
    assign w_push_req.data    = bus.s_data;

    // The queue only drains in cycles the pipeline leaves free.
    assign w_pop = !bus.p_valid && !w_empty;

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_wb_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push     (w_push),
        .i_push_req (w_push_req),
        .i_pop      (w_pop),
        .i_inv_en   (bus.p_valid),
        .i_inv_reg  (bus.p_reg),
        .i_q_reg1   (bus.q_reg1),
        .i_q_reg2   (bus.q_reg2),
        .o_head     (w_head),
        .o_empty    (w_empty),
        .o_count    (w_count),
        .o_match1   (w_match1),
        .o_match2   (w_match2)
    );

    // ------------------------------------------------------------------
    // Register-file write stage: at most one write per cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_regwrite <= 1'b0;
            r_wreg     <= '0;
            r_wdata    <= '0;
        end else if (bus.p_valid) begin
            r_regwrite <= (bus.p_reg != ZERO_REG);
            r_wreg     <= bus.p_reg;
            r_wdata    <= bus.p_data;
        end else if (w_pop) begin
            // A squashed head is still popped, it just writes nothing.
            r_regwrite <= w_head.valid;
            r_wreg     <= w_head.dst_reg;
            r_wdata    <= w_head.data;
        end else begin
            r_regwrite <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Starvation: count cycles where the pipeline blocks a non-empty
    // queue. stall_req follows the saturated counter by one cycle and
    // drops in the cycle right after a pop.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve <= '0;
            r_stall  <= 1'b0;
        end else begin
            r_stall <= !w_pop && (r_starve == c_limit);
            if (w_pop) begin
                r_starve <= '0;
            end else if (bus.p_valid && !w_empty && (r_starve != c_limit)) begin
                r_starve <= r_starve + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Hazard lookups. The output-stage term covers the write being
    // performed this cycle, which readers cannot see yet.
    // ------------------------------------------------------------------
    assign bus.q_pend1 = (bus.q_reg1 != ZERO_REG) &&
                         (w_match1 || (r_regwrite && (r_wreg == bus.q_reg1)));
    assign bus.q_pend2 = (bus.q_reg2 != ZERO_REG) &&
                         (w_match2 || (r_regwrite && (r_wreg == bus.q_reg2)));

    assign bus.s_ready   = w_s_ready;
    assign bus.stall_req = r_stall;
    assign bus.W_reg     = r_wreg;
    assign bus.W_data    = r_wdata;
    assign bus.RegWrite  = r_regwrite;

endmodule : regfile_wb_arbiter
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_arbiter
// Description : Self-checking bench for regfile_wb_arbiter. A queue-based
//               reference model predicts every register-file write (with the
//               cycle it must appear in) into a scoreboard; an independent
//               monitor pops and compares whenever RegWrite is seen.
//               Combinational outputs are checked against the model each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    localparam int DEPTH        = 4;
    localparam int STARVE_LIMIT = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if bus();

    regfile_wb_arbiter #(
        .DEPTH        (DEPTH),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
        logic        v;
    } ment_t;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
        int          cyc;
    } exp_t;

    ment_t m_q[$];     // model of queued secondary writes, oldest first
    exp_t  sb[$];      // expected register-file writes, in order
    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    logic       m_wr_v  = 1'b0;   // model: a write is on the RF port this cycle
    logic [4:0] m_wr_r  = '0;
    int         m_blocked = 0;    // cycles the queue was blocked since last pop
    logic       m_stall = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s @cycle %0d: got %0h want %0h", name, cyc, act, want);
        end
    endtask

    // Monitor: consumes expected writes as the DUT produces them.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            check("regwrite_in_reset", {31'd0, bus.RegWrite}, 32'd0);
        end else if (bus.RegWrite) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write @cycle %0d: got reg %0d data %0h want none",
                         cyc, bus.W_reg, bus.W_data);
            end else begin
                e = sb.pop_front();
                check("w_reg",   {27'd0, bus.W_reg}, {27'd0, e.r});
                check("w_data",  bus.W_data, e.d);
                check("w_cycle", cyc, e.cyc);
            end
        end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
            total++;
            bad++;
            $display("FAIL missing_write @cycle %0d: got none want reg %0d data %0h",
                     cyc, sb[0].r, sb[0].d);
            void'(sb.pop_front());
        end
    end

    function automatic logic pend(input logic [4:0] q);
        if (q == 5'd0) return 1'b0;
        foreach (m_q[i]) if (m_q[i].v && m_q[i].r == q) return 1'b1;
        return m_wr_v && (m_wr_r == q);
    endfunction

    // One clock cycle of stimulus plus the model's view of that cycle.
    task automatic step(input logic pv, input logic [4:0] pr, input logic [31:0] pd,
                        input logic sv, input logic [4:0] sr, input logic [31:0] sd,
                        input logic [4:0] q1, input logic [4:0] q2);
        logic  acc, pop, nonempty, wr;
        ment_t h;
        @(posedge clk);
        #1;
        bus.p_valid = pv; bus.p_reg = pr; bus.p_data = pd;
        bus.s_valid = sv; bus.s_reg = sr; bus.s_data = sd;
        bus.q_reg1  = q1; bus.q_reg2 = q2;
        #1;
        check("s_ready",   {31'd0, bus.s_ready},   {31'd0, (m_q.size() < DEPTH)});
        check("q_pend1",   {31'd0, bus.q_pend1},   {31'd0, pend(q1)});
        check("q_pend2",   {31'd0, bus.q_pend2},   {31'd0, pend(q2)});
        check("stall_req", {31'd0, bus.stall_req}, {31'd0, m_stall});

        nonempty = (m_q.size() > 0);
        acc      = sv && (m_q.size() < DEPTH);
        pop      = !pv && nonempty;
        wr       = 1'b0;
        if (pv) begin
            foreach (m_q[i]) if (m_q[i].r == pr) m_q[i].v = 1'b0;
            if (pr != 5'd0) begin
                sb.push_back('{pr, pd, cyc + 1});
                wr = 1'b1;
                m_wr_r = pr;
            end
        end else if (pop) begin
            h = m_q.pop_front();
            if (h.v) begin
                sb.push_back('{h.r, h.d, cyc + 1});
                wr = 1'b1;
                m_wr_r = h.r;
            end
        end
        m_stall = !pop && (m_blocked >= STARVE_LIMIT);
        if (pop) m_blocked = 0;
        else if (pv && nonempty) m_blocked++;
        if (acc) m_q.push_back('{sr, sd, (sr != 5'd0) && !(pv && pr == sr)});
        m_wr_v = wr;
    endtask

    task automatic idle(input logic [4:0] q1, input logic [4:0] q2);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, q1, q2);
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus.p_valid = 1'b0;
        bus.s_valid = 1'b0;
        sb.delete();
        m_q.delete();
        m_wr_v = 1'b0;
        m_blocked = 0;
        m_stall = 1'b0;
        #1;
        check("s_ready_in_reset",   {31'd0, bus.s_ready},   32'd0);
        check("stall_req_in_reset", {31'd0, bus.stall_req}, 32'd0);
        check("w_reg_in_reset",     {27'd0, bus.W_reg},     32'd0);
        check("w_data_in_reset",    bus.W_data,             32'd0);
        repeat (n) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog @cycle %0d: got timeout want finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic       pv, sv;
        logic [4:0] pr, sr, q1, q2;
        bus.p_valid = 1'b0; bus.p_reg = '0; bus.p_data = '0;
        bus.s_valid = 1'b0; bus.s_reg = '0; bus.s_data = '0;
        bus.q_reg1  = '0;   bus.q_reg2 = '0;

        do_reset(2);

        // 1: primary only
        step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
        idle(5'd5, 5'd0);
        idle(5'd5, 5'd0);

        // 2: secondary through an idle arbiter
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h1234, 5'd9, 5'd0);
        repeat (3) idle(5'd9, 5'd0);

        // 3: fill while blocked, refuse when full, drain in order
        for (int i = 0; i < 4; i++)
            step(1'b1, 5'(10 + i), 32'(i), 1'b1, 5'(1 + i), 32'(100 + i), 5'(1 + i), 5'(10 + i));
        step(1'b1, 5'd14, 32'd4, 1'b1, 5'd5, 32'd105, 5'd5, 5'd4);
        repeat (6) idle(5'd1, 5'd4);

        // 4: squash of a queued write by a newer pipeline write
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hAAAA, 5'd7, 5'd0);
        step(1'b1, 5'd7, 32'hBBBB, 1'b0, 5'd0, 32'd0, 5'd7, 5'd0);
        repeat (3) idle(5'd7, 5'd0);

        // 5a: starvation
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd20, 32'h55, 5'd20, 5'd21);
        for (int i = 0; i < 12; i++)
            step(1'b1, 5'd21, 32'(i), 1'b0, 5'd0, 32'd0, 5'd20, 5'd21);
        repeat (3) idle(5'd20, 5'd21);

        // 5b: reset with writes queued and in flight
        for (int i = 0; i < 3; i++)
            step(1'b1, 5'd22, 32'(i), 1'b1, 5'(23 + i), 32'(i), 5'd23, 5'd22);
        do_reset(2);
        repeat (6) idle(5'd23, 5'd24);

        // 6: register zero
        step(1'b1, 5'd0, 32'h11, 1'b1, 5'd0, 32'h22, 5'd0, 5'd0);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h33, 5'd0, 5'd0);
        repeat (4) idle(5'd0, 5'd0);

        // Random traffic over a small register set to provoke collisions
        for (int n = 0; n < 400; n++) begin
            if (n == 200) do_reset(1);
            pv = (n < 200) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0);
            sv = ($urandom_range(0, 1) == 1);
            pr = 5'($urandom_range(0, 7));
            sr = 5'($urandom_range(0, 7));
            q1 = 5'($urandom_range(0, 7));
            q2 = 5'($urandom_range(0, 7));
            step(pv, pr, $urandom, sv, sr, $urandom, q1, q2);
        end
        repeat (DEPTH + 3) idle(5'd1, 5'd2);
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_regfile_wb_arbiter
`default_nettype wire
